// File: rtl/lock_pkg.sv
// Shared types and constants for the code-entry lock: FSM state encoding,
// BCD digit geometry and the digit-increment helper.
package lock_pkg;

    localparam int DIGIT_W    = 4;
    localparam int NUM_DIGITS = 4;

    typedef enum logic [1:0] {
        ST_ENTRY   = 2'd0,
        ST_CHECK   = 2'd1,
        ST_OPEN    = 2'd2,
        ST_LOCKOUT = 2'd3
    } state_t;

    // BCD increment: 9 (or any out-of-range value) wraps to 0.
    function automatic logic [DIGIT_W-1:0] bcd_inc(input logic [DIGIT_W-1:0] d);
        return (d >= DIGIT_W'(9)) ? '0 : d + DIGIT_W'(1);
    endfunction

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchroniser plus edge detector for the asynchronous count-enable
// toggle; rise/fall are single-cycle pulses on the synchronised value.
module sync_edge (
    input  logic clk_in,
    input  logic rst_n,
    input  logic i_din,
    output logic rise,
    output logic fall
);

    logic       r_sync1;
    logic       r_sync2;
    logic       r_prev;
    logic [2:0] r_fill;

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_prev  <= 1'b0;
            r_fill  <= 3'b000;
        end else begin
            r_sync1 <= i_din;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
            r_fill  <= {r_fill[1:0], 1'b1};
        end
    end

    // Edges are only trusted once the history holds a real sampled level, so an
    // input already high when reset is released does not look like a press.
    assign rise = r_fill[2] &  r_sync2 & ~r_prev;
    assign fall = r_fill[2] & ~r_sync2 &  r_prev;

endmodule

// File: rtl/code_entry.sv
// Four-digit BCD combination lock: digits are dialled by holding the count
// enable, checked against CODE, and repeated failures trigger a lockout.
module code_entry
    import lock_pkg::*;
#(
    parameter int          TICK_DIV       = 50_000_000,
    parameter logic [15:0] CODE           = 16'h1234,
    parameter int          MAX_FAILS      = 3,
    parameter int          OPEN_CYCLES    = 500_000_000,
    parameter int          LOCKOUT_CYCLES = 1_000_000_000
) (
    input  logic       clk_in,
    input  logic       rst_n,
    input  logic       enb_cnt,
    output logic       enb_lock,
    output logic       disable_cnt,
    output logic [3:0] digit,
    output logic [1:0] digit_idx,
    output logic       unlocked
);

    localparam int MAX_DUR = (OPEN_CYCLES > LOCKOUT_CYCLES) ? OPEN_CYCLES : LOCKOUT_CYCLES;
    localparam int DUR_W   = $clog2(MAX_DUR + 1);
    localparam int PRESC_W = $clog2(TICK_DIV + 1);
    localparam int FAIL_W  = $clog2(MAX_FAILS + 1);
    localparam int CODE_W  = DIGIT_W * NUM_DIGITS;

    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);
    localparam logic [DUR_W-1:0]   OPEN_LAST  = DUR_W'(OPEN_CYCLES - 1);
    localparam logic [DUR_W-1:0]   LOCK_LAST  = DUR_W'(LOCKOUT_CYCLES - 1);
    localparam logic [1:0]         IDX_LAST   = 2'(NUM_DIGITS - 1);

    state_t               r_state;
    logic                 r_counting;
    logic [PRESC_W-1:0]   r_presc;
    logic [DIGIT_W-1:0]   r_digit;
    logic [1:0]           r_idx;
    logic [CODE_W-1:0]    r_code;
    logic [FAIL_W-1:0]    r_fails;
    logic [DUR_W-1:0]     r_dur;

    logic                 w_rise;
    logic                 w_fall;

    sync_edge u_sync_edge (
        .clk_in (clk_in),
        .rst_n  (rst_n),
        .i_din  (enb_cnt),
        .rise   (w_rise),
        .fall   (w_fall)
    );

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_ENTRY;
            r_counting <= 1'b0;
            r_presc    <= '0;
            r_digit    <= '0;
            r_idx      <= '0;
            r_code     <= '0;
            r_fails    <= '0;
            r_dur      <= '0;
        end else begin
            case (r_state)
                ST_ENTRY: begin
                    if (w_rise) begin
                        r_counting <= 1'b1;
                        r_presc    <= '0;
                    end else if (r_counting) begin
                        if (r_presc == PRESC_LAST) begin
                            r_presc <= '0;
                            r_digit <= bcd_inc(r_digit);
                        end else begin
                            r_presc <= r_presc + PRESC_W'(1);
                        end
                    end
                    // Slot 0 lives in the top nibble, so slot i sits at bit (3-i)*4.
                    if (w_fall && r_counting) begin
                        r_code[{~r_idx, 2'b00} +: DIGIT_W] <= r_digit;
                        r_counting <= 1'b0;
                        r_presc    <= '0;
                        r_digit    <= '0;
                        r_idx      <= r_idx + 2'd1;
                        if (r_idx == IDX_LAST) begin
                            r_state <= ST_CHECK;
                        end
                    end
                end

                ST_CHECK: begin
                    // Every path back to ENTRY passes through here, so the
                    // entry context is wiped once, after the comparison.
                    r_code     <= '0;
                    r_idx      <= '0;
                    r_digit    <= '0;
                    r_counting <= 1'b0;
                    r_presc    <= '0;
                    r_dur      <= '0;
                    if (r_code == CODE) begin
                        r_state <= ST_OPEN;
                        r_fails <= '0;
                    end else if (int'(r_fails) + 1 >= MAX_FAILS) begin
                        r_state <= ST_LOCKOUT;
                        r_fails <= '0;
                    end else begin
                        r_state <= ST_ENTRY;
                        r_fails <= r_fails + FAIL_W'(1);
                    end
                end

                ST_OPEN: begin
                    if (r_dur == OPEN_LAST) begin
                        r_state <= ST_ENTRY;
                        r_dur   <= '0;
                    end else begin
                        r_dur <= r_dur + DUR_W'(1);
                    end
                end

                ST_LOCKOUT: begin
                    if (r_dur == LOCK_LAST) begin
                        r_state <= ST_ENTRY;
                        r_dur   <= '0;
                    end else begin
                        r_dur <= r_dur + DUR_W'(1);
                    end
                end

                default: begin
                    r_state <= ST_ENTRY;
                end
            endcase
        end
    end

    assign enb_lock    = (r_state == ST_ENTRY);
    assign disable_cnt = (r_state == ST_LOCKOUT);
    assign unlocked    = (r_state == ST_OPEN);
    assign digit       = r_digit;
    assign digit_idx   = r_idx;

endmodule
